mem_word_bridge: RTL and testbench
==================================

# mem_word_bridge

Sequential bridge between the CPU load/store stage and the 8-bit byte-wide data RAM. It accepts one 32-bit load or store request through a valid/ready handshake and splits it into four little-endian byte accesses on the RAM's bidirectional bus. It generates the RAM's level `read` enable and edge-sensitive `write` strobe, and returns one response pulse per request. All RAM-side signals are registered.

## Interface
- `ADDR_W`, default 8: byte address width; matches the RAM address width.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  bridge can accept a request; high only in IDLE.
- `req_we`  input  1  1 = store, 0 = load.
- `req_addr`  input  ADDR_W  byte address of byte 0 (LSB); no alignment requirement.
- `req_wdata`  input  32  store data.
- `rsp_valid`  output  1  one-cycle completion pulse for both load and store.
- `rsp_rdata`  output  32  load data; holds its value until the next load completes.
- `ram_data`  inout  8  RAM data bus; driven only in write states, otherwise high-Z.
- `ram_addr`  output  ADDR_W  RAM address.
- `ram_read`  output  1  RAM read enable, level.
- `ram_write`  output  1  RAM write strobe; the RAM latches on its rising edge.
- Clock and reset: one clock; reset is synchronous and active-low.

## Operation
- States: IDLE, WSETUP, WSTROBE, RDBYTE, DONE; 2-bit byte counter `idx`.
- IDLE: `req_ready`=1. On `req_valid && req_ready`:
  - Latch `req_we`, `req_addr`, and `req_wdata`.
  - Clear `idx`.
  - Go to WSETUP if store, otherwise RDBYTE.
- WSETUP:
  - `ram_addr` = `addr + idx` (mod 2^ADDR_W).
  - `ram_data` drives `wdata[8*idx +: 8]`.
  - `ram_write`=0, `ram_read`=0.
  - Next state: WSTROBE.
- WSTROBE:
  - Same address and data held.
  - `ram_write`=1.
  - If `idx`==3, go to DONE; otherwise increment `idx` and go to WSETUP.
- RDBYTE:
  - `ram_addr` = `addr + idx`, `ram_read`=1, `ram_data` high-Z.
  - At the end of the cycle, capture `ram_data` into `rdata[8*idx +: 8]`.
  - If `idx`==3, go to DONE; otherwise increment `idx`.
- DONE: `rsp_valid`=1 for exactly one cycle. `rsp_rdata` updates only for loads. Next state: IDLE.
- Invariants:
  - `ram_read` and `ram_write` are never both 1.
  - `ram_data` is never driven while `ram_read`=1.
- Requests presented while not in IDLE are not accepted; the requester holds them.

## Timing
- Acceptance edge = cycle 0.
- Load latency:
  - Byte reads occur in cycles 1–4.
  - `rsp_valid` is high in cycle 5.
  - `req_ready` returns high in cycle 6.
- Store latency:
  - Byte pairs occupy cycles 1–8.
  - `ram_write` rises at the start of cycles 2, 4, 6, 8.
  - `rsp_valid` is high in cycle 9.
  - `req_ready` returns high in cycle 10.
- Strobe setup: address and data are stable for one full cycle before each `ram_write` rising edge, and through its high phase.
- Address wrap: `addr + idx` wraps modulo 2^ADDR_W; 0xFE → bytes at 0xFE, 0xFF, 0x00, 0x01.
- Reset values (while `rst_n`=0 at a clock edge):
  - state IDLE, `idx`=0.
  - `req_ready`=0 during reset; it is 1 in the first cycle after `rst_n` rises.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - `ram_addr`=0, `ram_read`=0, `ram_write`=0, `ram_data` high-Z.
- Reset mid-operation:
  - The operation is abandoned and no response is produced.
  - `ram_write` falls at the reset edge and no further rising edge is generated.
  - Bytes already strobed remain written; the remaining bytes are untouched.

## Configuration
- `MEM_BRIDGE_BYTE_EN` defined:
  - Adds input `req_byte` (1 bit), latched at acceptance.
  - When `req_byte`=1, only byte 0 is transferred.
  - Store: WSETUP/WSTROBE once, `rsp_valid` in cycle 3.
  - Load: RDBYTE once, `rsp_valid` in cycle 2; `rsp_rdata` = {24'h0, byte}.
- `MEM_BRIDGE_BYTE_EN` undefined: the `req_byte` port is absent and every access is a full 4-byte word.

## Test plan
- Store then load round trip:
  - Store 0xDEADBEEF @0x10 → RAM[0x10..0x13] = EF, BE, AD, DE.
  - Four `ram_write` rising edges; `rsp_valid` in cycle 9.
  - Load @0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_valid` in cycle 5.
- Address wrap:
  - Store 0x11223344 @0xFE → RAM[0xFE]=44, RAM[0xFF]=33, RAM[0x00]=22, RAM[0x01]=11.
  - Load @0xFE returns 0x11223344.
- Busy backpressure:
  - Hold `req_valid`=1 with a second request during a store.
  - `req_ready`=0 until cycle 10; the second request is accepted at cycle 10 and executes correctly.
- Reset mid-store:
  - Deassert `rst_n` in cycle 5 of a store of 0xAABBCCDD @0x20 (preload 0x00).
  - RAM[0x20]=DD, RAM[0x21]=CC, RAM[0x22..0x23] remain 00.
  - No `rsp_valid`; all outputs at reset values.
- Bus contention checker across random loads/stores: `ram_read`&`ram_write` never 1; `ram_data` never driven while `ram_read`=1.
- With `MEM_BRIDGE_BYTE_EN`:
  - Byte store 0x5A @0x30 leaves RAM[0x31] unchanged.
  - Byte load @0x30 → `rsp_rdata`=0x0000005A in cycle 2.

Source files
------------

// File: rtl/mem_word_bridge.sv
// 32-bit load/store to 8-bit byte-RAM bridge: four little-endian byte accesses per word.
// Optional single-byte accesses when MEM_BRIDGE_BYTE_EN is defined (adds req_byte).
module mem_word_bridge #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
`ifdef MEM_BRIDGE_BYTE_EN
  input  logic              req_byte,
`endif
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  inout  wire  [7:0]        ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write
);

  typedef enum logic [2:0] {IDLE, WSETUP, WSTROBE, RDBYTE, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [ADDR_W-1:0] addr_q, addr_base;
  logic [31:0]       wdata_q, wdata_base;
  logic [31:0]       rdata_q, rd_merged, rd_word;
  logic [7:0]        dout;
  logic              oe;
  logic              accept;
  logic              last;
  logic              byte_q;

`ifdef MEM_BRIDGE_BYTE_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      byte_q <= 1'b0;
    else if (accept) byte_q <= req_byte;
  end
`else
  assign byte_q = 1'b0;
`endif

  assign ram_data = oe ? dout : 8'hzz;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    last      = byte_q ? (idx == 2'd0) : (idx == 2'd3);
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          idx_nxt   = 2'd0;
          state_nxt = req_we ? WSETUP : RDBYTE;
        end
      end
      WSETUP:  state_nxt = WSTROBE;
      WSTROBE: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = WSETUP;
        end
      end
      RDBYTE: begin
        if (last) state_nxt = DONE;
        else      idx_nxt   = idx + 2'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM-side outputs are computed from the next state so they are registered yet aligned
  always_comb begin
    addr_base  = accept ? req_addr  : addr_q;
    wdata_base = accept ? req_wdata : wdata_q;
    rd_merged  = rdata_q;
    rd_merged[8*idx +: 8] = ram_data;
    rd_word    = byte_q ? {24'h0, ram_data} : rd_merged;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      ram_addr  <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      oe        <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == DONE);
      ram_read  <= (state_nxt == RDBYTE);
      ram_write <= (state_nxt == WSTROBE);
      oe        <= (state_nxt == WSETUP) || (state_nxt == WSTROBE);
      if (state_nxt == WSETUP || state_nxt == RDBYTE)
        ram_addr <= addr_base + ADDR_W'(idx_nxt);
      if (state == RDBYTE && last)
        rsp_rdata <= rd_word;
    end
  end

  // Datapath registers carry no reset; their contents only matter once a request is latched
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state == RDBYTE)
      rdata_q <= rd_merged;
    if (state_nxt == WSETUP)
      dout <= wdata_base[8*idx_nxt +: 8];
  end

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge with a behavioural byte RAM on the shared bus.
`timescale 1ns/1ps
module tb_mem_word_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, ram_read, ram_write;
  logic [31:0] rsp_rdata;
  logic [7:0]  ram_addr;
  wire  [7:0]  ram_data;

  logic [7:0]  mem   [256] = '{default: 8'h00};
  logic [7:0]  model [256] = '{default: 8'h00};
  int          asserts = 0;
  int          failures = 0;
  int          wr_edges = 0;

  mem_word_bridge #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_BRIDGE_BYTE_EN
    .req_byte  (req_byte),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_read  (ram_read),
    .ram_write (ram_write)
  );

  always #5 clk = ~clk;

  assign ram_data = ram_read ? mem[ram_addr] : 8'hzz;

  always @(posedge ram_write) begin
    mem[ram_addr] <= ram_data;
    wr_edges      <= wr_edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_excl", {31'h0, ram_read & ram_write}, 32'h0);
      if (ram_read) chk("bus_contention", {24'h0, ram_data}, {24'h0, mem[ram_addr]});
    end
  end

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic bm, output int lat, output logic [31:0] rd, output int nwr);
    int n, w0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_byte = bm;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    w0 = wr_edges;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
    rd  = rsp_rdata;
    nwr = wr_edges - w0;
    if (we) for (int i = 0; i < (bm ? 1 : 4); i++) model[8'(addr + i)] = wd[8*i +: 8];
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [7];
  int          lat, nwr, rc, bad;
  logic [31:0] rd, last_rd, exp;

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        9};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 5};
    vecs[2] = '{1'b1, 8'hFE, 32'h11223344, 32'h0,        9};
    vecs[3] = '{1'b0, 8'hFE, 32'h0,        32'h11223344, 5};
    vecs[4] = '{1'b1, 8'h80, 32'h01020304, 32'h0,        9};
    vecs[5] = '{1'b0, 8'h80, 32'h0,        32'h01020304, 5};
    vecs[6] = '{1'b0, 8'h0F, 32'h0,        32'hADBEEF00, 5};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
    chk("rst_ram_read", {31'h0, ram_read}, 32'h0);
    chk("rst_ram_write", {31'h0, ram_write}, 32'h0);
    chk("rst_ram_data_z", {31'h0, ram_data === 8'hzz}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    last_rd = 32'h0;
    for (int v = 0; v < 7; v++) begin
      do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, 1'b0, lat, rd, nwr);
      chk($sformatf("lat_v%0d", v), lat, vecs[v].exp_lat);
      if (vecs[v].we) begin
        chk($sformatf("nwr_v%0d", v), nwr, 4);
        chk($sformatf("rdata_hold_v%0d", v), rd, last_rd);
        for (int i = 0; i < 4; i++)
          chk($sformatf("mem_v%0d_b%0d", v, i), {24'h0, mem[8'(vecs[v].addr + i)]},
              {24'h0, vecs[v].wdata[8*i +: 8]});
      end else begin
        chk($sformatf("rdata_v%0d", v), rd, vecs[v].exp_rdata);
        last_rd = vecs[v].exp_rdata;
      end
      @(negedge clk);
      chk($sformatf("ready_ret_v%0d", v), {31'h0, req_ready}, 32'h1);
    end
    chk("mem_fe", {24'h0, mem[8'hFE]}, 32'h44);
    chk("mem_ff", {24'h0, mem[8'hFF]}, 32'h33);
    chk("mem_00", {24'h0, mem[8'h00]}, 32'h22);
    chk("mem_01", {24'h0, mem[8'h01]}, 32'h11);
    chk("mem_10", {24'h0, mem[8'h10]}, 32'hEF);
    chk("mem_13", {24'h0, mem[8'h13]}, 32'hDE);

    // busy backpressure: second request held during a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 32'hCAFEF00D; req_byte = 1'b0;
    bad = 0;
    while (!req_ready && bad < 50) begin @(negedge clk); bad++; end
    @(posedge clk);
    #1 req_we = 1'b0;
    bad = 0; rc = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (req_ready) bad++;
      if (rsp_valid) rc = c;
    end
    chk("busy_ready_low", bad, 0);
    chk("busy_store_rsp_cycle", rc, 9);
    @(negedge clk);
    chk("busy_ready_c10", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
    chk("busy_load_lat", lat, 5);
    chk("busy_load_rdata", rsp_rdata, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) model[8'h40 + i] = mem[8'h40 + i];

    // reset in cycle 5 of a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 32'hAABBCCDD;
    bad = 0;
    while (!req_ready && bad < 50) begin @(negedge clk); bad++; end
    rc = wr_edges;
    @(posedge clk);
    #1 req_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_addr", {24'h0, ram_addr}, 32'h0);
    chk("mid_rst_write", {31'h0, ram_write}, 32'h0);
    chk("mid_rst_read", {31'h0, ram_read}, 32'h0);
    chk("mid_rst_data_z", {31'h0, ram_data === 8'hzz}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("mid_rst_no_rsp", bad, 0);
    chk("mid_rst_wr_edges", wr_edges - rc, 2);
    chk("mid_rst_m20", {24'h0, mem[8'h20]}, 32'hDD);
    chk("mid_rst_m21", {24'h0, mem[8'h21]}, 32'hCC);
    chk("mid_rst_m22", {24'h0, mem[8'h22]}, 32'h00);
    chk("mid_rst_m23", {24'h0, mem[8'h23]}, 32'h00);
    model[8'h20] = 8'hDD; model[8'h21] = 8'hCC;

    // random traffic against the shadow model, bus checker active throughout
    for (int t = 0; t < 20; t++) begin
      logic        rwe;
      logic [7:0]  ra;
      logic [31:0] rw;
      rwe = 1'($urandom_range(0, 1));
      ra  = 8'($urandom);
      rw  = $urandom;
      exp = {model[8'(ra + 3)], model[8'(ra + 2)], model[8'(ra + 1)], model[ra]};
      do_req(rwe, ra, rw, 1'b0, lat, rd, nwr);
      chk($sformatf("rnd_lat_%0d", t), lat, rwe ? 9 : 5);
      if (!rwe) chk($sformatf("rnd_rdata_%0d", t), rd, exp);
    end

`ifdef MEM_BRIDGE_BYTE_EN
    do_req(1'b1, 8'h30, 32'h99887766, 1'b0, lat, rd, nwr);
    do_req(1'b1, 8'h30, 32'hFFFFFF5A, 1'b1, lat, rd, nwr);
    chk("byte_store_lat", lat, 3);
    chk("byte_store_nwr", nwr, 1);
    chk("byte_m30", {24'h0, mem[8'h30]}, 32'h5A);
    chk("byte_m31", {24'h0, mem[8'h31]}, 32'h77);
    do_req(1'b0, 8'h30, 32'h0, 1'b1, lat, rd, nwr);
    chk("byte_load_lat", lat, 2);
    chk("byte_load_rdata", rd, 32'h0000005A);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
